// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and tag type for the NTT Barrett reduction path
package ntt_pkg;
  localparam int RES_W = 13;
  localparam logic [RES_W-1:0] Q = 13'd3329;
  localparam int BARRETT_LAT = 2;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W = $clog2(NUM_REQ_DEF);
  typedef struct packed {
    logic vld;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/Barret.sv
// Barret: 2-stage pipelined signed Barrett reduction, r = c mod 3329 in 0..3328
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   c    in  signed operand, |c| <= 3328^2
//   r    out reduced result, valid 2 edges after c
module Barret
  import ntt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [2*WIDTH-1:0] c,
  output logic [RES_W-1:0]        r
);
  localparam int XW = 2*WIDTH+1;
  // Q*3329 exceeds 3328^2, so adding it makes the operand non-negative without changing the residue
  localparam logic signed [XW-1:0] OFF = XW'(11082241);
  // floor(2^36 / 3329); quotient estimate is low by at most one
  localparam logic [24:0] M = 25'd20642678;
  logic [XW-1:0] x;
  logic [XW+24:0] p;
  logic [RES_W-1:0] x_q, q_q, t;
  assign x = XW'(c) + OFF;
  assign p = (XW+25)'(x) * (XW+25)'(M);
  // the remainder is below 2*Q < 2^13, so modulo-2^13 arithmetic is exact
  assign t = x_q - q_q * Q;
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      q_q <= '0;
      r   <= '0;
    end else begin
      x_q <= x[RES_W-1:0];
      q_q <= RES_W'(p >> 36);
      r   <= t >= Q ? t - Q : t;
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first eligible at or above ptr
//   elig in  eligible requesters
//   ptr  in  highest-priority requester index
//   gnt  out one-hot grant or zero
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);
  always_comb begin
    int idx;
    int sel;
    sel = -1;
    idx = 0;
    // walk downward so the last hit is the nearest one to ptr
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (|(elig & (N'(1) << idx))) sel = idx;
    end
    gnt = sel < 0 ? '0 : N'(1) << sel;
  end
endmodule

// File: rtl/barrett_rr_sched.sv
// barrett_rr_sched: round-robin sharing of one Barrett reducer among NUM_REQ requesters
//   clk_i, rst_ni           clock, async active-low reset
//   req_valid_i/ready_o     operand handshake per requester, req_data_i signed operand
//   rsp_valid_o/ready_i     result handshake per requester, rsp_data_o result (FIFO head)
//   busy_o                  anything in flight or buffered
module barrett_rr_sched
  import ntt_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int OUT_DEPTH = 4,
  parameter int LAT       = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][2*WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  input  logic [NUM_REQ-1:0]                 rsp_ready_i,
  output logic [NUM_REQ-1:0][RES_W-1:0]      rsp_data_o,
  output logic                               busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(OUT_DEPTH+1);
  localparam int PW = $clog2(OUT_DEPTH);
  if (LAT != BARRETT_LAT || NUM_REQ < 2 || NUM_REQ > 2**ID_W) begin : g_bad_param
    $error("barrett_rr_sched: unsupported parameters");
  end
  logic [IW-1:0] ptr, gidx;
  logic [NUM_REQ-1:0] elig, gnt, push, pop;
  logic [CW-1:0] credit [NUM_REQ];
  logic [CW-1:0] cnt [NUM_REQ];
  logic [PW-1:0] rd [NUM_REQ];
  logic [PW-1:0] wr [NUM_REQ];
  logic [RES_W-1:0] mem [NUM_REQ][OUT_DEPTH];
  tag_t tp [LAT];
  tag_t tl;
  logic acc;
  logic signed [2*WIDTH-1:0] c;
  logic [RES_W-1:0] r;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.elig(elig), .ptr(ptr), .gnt(gnt));
  Barret #(.WIDTH(WIDTH)) u_red (.clk(clk_i), .rst(~rst_ni), .c(c), .r(r));
  // gating with rst_ni keeps ready low while reset is held, even with valid inputs
  assign req_ready_o = rst_ni ? gnt : '0;
  assign acc = |req_ready_o;
  assign c = acc ? req_data_i[gidx] : '0;
  assign tl = tp[LAT-1];
  always_comb begin
    elig = '0;
    push = '0;
    pop = '0;
    gidx = '0;
    rsp_valid_o = '0;
    rsp_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && credit[i] < CW'(OUT_DEPTH);
      if (gnt[i]) gidx = IW'(i);
      rsp_valid_o[i] = cnt[i] != '0;
      rsp_data_o[i] = rsp_valid_o[i] ? mem[i][rd[i]] : '0;
      push[i] = tl.vld && tl.id == ID_W'(i);
      pop[i] = rsp_valid_o[i] && rsp_ready_i[i];
    end
  end
  always_comb begin
    busy_o = |rsp_valid_o;
    for (int s = 0; s < LAT; s++) busy_o = busy_o | tp[s].vld;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
      for (int s = 0; s < LAT; s++) tp[s] <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit[i] <= '0;
        cnt[i] <= '0;
        rd[i] <= '0;
        wr[i] <= '0;
      end
    end else begin
      if (acc) ptr <= gidx == IW'(NUM_REQ-1) ? '0 : gidx + 1'b1;
      tp[0] <= '{vld: acc, id: ID_W'(gidx)};
      for (int s = 1; s < LAT; s++) tp[s] <= tp[s-1];
      for (int i = 0; i < NUM_REQ; i++) begin
        credit[i] <= credit[i] + CW'(req_ready_o[i]) - CW'(pop[i]);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) wr[i] <= wr[i] == PW'(OUT_DEPTH-1) ? '0 : wr[i] + 1'b1;
        if (pop[i]) rd[i] <= rd[i] == PW'(OUT_DEPTH-1) ? '0 : rd[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) mem[i][wr[i]] <= r;
      if (rst_ni) assert (!(push[i] && !pop[i] && cnt[i] == CW'(OUT_DEPTH)));
    end
  end
endmodule

// File: tb/tb_barrett_rr_sched.sv
// tb_barrett_rr_sched: directed self-checking bench for barrett_rr_sched
module tb_barrett_rr_sched;
  logic clk = 0;
  logic rst_ni = 0;
  logic [3:0] valid = '0;
  logic [3:0] rsp_ready = '0;
  logic [3:0] ready, rsp_valid;
  logic [3:0][31:0] data = '0;
  logic [3:0][12:0] rsp_data;
  logic busy;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  barrett_rr_sched dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(valid), .req_ready_o(ready),
    .req_data_i(data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_rsp(input int i, input int lim);
    int k = 0;
    while (!rsp_valid[i] && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rsp arrives", 32'(rsp_valid[i]), 1);
  endtask
  task automatic drain();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drain idle", 32'(busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] gprev, seen;
    logic [31:0] exp2 [4];
    int nxt, got;
    exp2 = '{1, 3328, 0, 0};
    #1;
    chk("rst ready", 32'(ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst busy", 32'(busy), 0);
    @(negedge clk);
    rst_ni = 1;
    rsp_ready = 4'hF;
    // test 1: single operand latency and value
    @(negedge clk);
    valid = 4'b0001;
    data[0] = 32'd12345;
    #1 chk("t1 grant", 32'(ready), 1);
    @(negedge clk);
    valid = '0;
    #1 chk("t1 e1 rsp", 32'(rsp_valid), 0);
    chk("t1 busy", 32'(busy), 1);
    @(negedge clk);
    #1 chk("t1 e2 rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    #1 chk("t1 e3 rsp", 32'(rsp_valid), 1);
    chk("t1 data", 32'(rsp_data[0]), 2358);
    @(negedge clk);
    #1 chk("t1 idle", 32'(busy), 0);
    // test 2: boundary operands on all ports
    gprev = '0;
    seen = '0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 0) begin
        valid = 4'hF;
        data[0] = 32'(3328 * 3328);
        data[1] = 32'hFFFF_FFFF;
        data[2] = 32'd3329;
        data[3] = 32'd6658;
      end else valid = valid & ~gprev;
      #1;
      gprev = ready;
      for (int i = 0; i < 4; i++)
        if (rsp_valid[i]) begin
          chk($sformatf("t2 data%0d", i), 32'(rsp_data[i]), exp2[i]);
          seen[i] = 1'b1;
        end
    end
    chk("t2 all seen", 32'(seen), 32'hF);
    drain();
    // test 3: rotation with all requesters valid; pointer sits at 1 after test 2
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) valid = 4'hF;
      #1 chk($sformatf("t3 grant%0d", k), 32'(ready), 32'(4'(1) << ((1 + k) % 4)));
    end
    @(negedge clk);
    valid = '0;
    drain();
    // test 4/5: requester 1 blocked by its credit limit, requester 2 unaffected
    nxt = 0;
    gprev = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) begin
        valid = 4'b0110;
        rsp_ready = 4'b1101;
        data[1] = 32'd1000;
        data[2] = 32'd7;
      end else if (gprev[1]) begin
        nxt++;
        data[1] = 32'(1000 + nxt);
      end
      #1;
      gprev = ready;
    end
    chk("t4 accepted", 32'(nxt), 4);
    chk("t4 blocked", 32'(ready[1]), 0);
    chk("t4 other granted", 32'(ready[2]), 1);
    @(negedge clk);
    valid[2] = 1'b0;
    rsp_ready = 4'hF;
    #1 chk("t4 full ready", 32'(ready[1]), 0);
    chk("t4 head", 32'(rsp_data[1]), 1000);
    got = 1;
    gprev = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gprev[1]) begin
        nxt++;
        data[1] = 32'(1000 + nxt);
        if (nxt == 6) valid[1] = 1'b0;
      end
      #1;
      gprev = ready;
      if (k == 0) chk("t5 acc+pop", 32'({ready[1], rsp_valid[1]}), 3);
      if (k == 1) chk("t5 credit held", 32'(ready[1]), 1);
      if (rsp_valid[1]) begin
        chk("t4 order", 32'(rsp_data[1]), 32'(1000 + got));
        got++;
      end
    end
    chk("t4 total sent", 32'(nxt), 6);
    chk("t4 total got", 32'(got), 6);
    drain();
    // test 6: reset with two operands in flight
    @(negedge clk);
    valid = 4'b0001;
    data[0] = 32'd100;
    @(negedge clk);
    valid = 4'b1000;
    data[3] = 32'd200;
    @(negedge clk);
    valid = '0;
    #1 chk("t6 in flight", 32'(busy), 1);
    #2;
    rst_ni = 0;
    valid = 4'hF;
    #1;
    chk("t6 rst ready", 32'(ready), 0);
    chk("t6 rst rsp_valid", 32'(rsp_valid), 0);
    chk("t6 rst busy", 32'(busy), 0);
    chk("t6 rst data", 32'(rsp_data[0]), 0);
    @(negedge clk);
    @(negedge clk);
    valid = '0;
    rst_ni = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk("t6 no stale", 32'({busy, rsp_valid}), 0);
    end
    @(negedge clk);
    valid = 4'b0001;
    data[0] = 32'd5;
    #1 chk("t6 grant", 32'(ready), 1);
    @(negedge clk);
    valid = '0;
    wait_rsp(0, 6);
    chk("t6 data", 32'(rsp_data[0]), 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
